shift_left_logical_pipelined: RTL and testbench
===============================================

// Module: shift_left_logical_pipelined
// PURPOSE
//  Pipelined logical left shifter: the left-shift counterpart of the ALU's
//  combinational right shifter, for multi-cycle shift ops in the ALU/execute path.
//  Log-structured: stage k conditionally shifts by 2^k, with one register per stage.
//  Valid/ready handshake on both sides. Sustains one result per cycle when not stalled.
// PARAMETERS
//  N       32          data width; power of 2; only N=32 is verified
//  S       $clog2(N)   stage count (derived, do not override); 5 for N=32
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         in/shamt carry a valid request
//  in_ready   out  1         block accepts request this cycle
//  in         in   N         operand
//  shamt      in   S         shift amount, 0..N-1
//  out_valid  out  1         out holds a valid result
//  out_ready  in   1         consumer accepts result this cycle
//  out        out  N         in << shamt, zero-filled from LSB
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits, data and shamt regs clear to 0.
//    out_valid=0 and out=0 immediately. in_ready=1 while rst_n=1 and pipe empty.
//  - Stage k (k=0..S-1) holds: v[k], d[k] (N bits), sa[k] (S bits).
//    Stage 0 loads d = shamt[0] ? in<<1 : in, sa = shamt, v = in_valid & in_ready.
//    Stage k>0 loads d = sa[k-1][k] ? d[k-1]<<(2^k) : d[k-1], sa = sa[k-1], v = v[k-1].
//    out = d[S-1], out_valid = v[S-1].
//  - Stall: stall = out_valid & ~out_ready. in_ready = ~stall (combinational).
//    While stall=1, every stage register holds its value. There is no per-stage bubble collapse.
//    A stall must not depend on in_valid (no comb path in_valid->in_ready).
//  - Latency: a request accepted at edge E0 appears with out_valid=1 after edge E(S-1).
//    For N=32 that is 5 register stages. Throughput 1/cycle when out_ready=1.
//  - Bubbles: cycles with in_valid=0 (while not stalled) load v[0]=0.
//    Bubbles propagate as invalid slots. Data in invalid slots is don't-care and
//    must never be presented with out_valid=1.
//  - Ordering: results leave in acceptance order. No drop, no duplication.
//  - Arithmetic: shifted-out MSBs are discarded and LSBs are zero-filled.
//    shamt=0 passes in unchanged. shamt=N-1 leaves only in[0] at out[N-1].
//  - Simultaneous: with stall=0, a new request enters stage 0 on the same edge
//    the last stage's result is consumed.
//  - Once out_valid=1, out and out_valid stay stable until out_ready=1.
//  - Reset mid-operation: all in-flight requests are discarded. No result
//    is emitted for them after reset deasserts.
// TESTING
//  1. Reset, then in=32'h0000_0001, shamt=31, in_valid pulse, out_ready=1
//     -> out=32'h8000_0000, out_valid=1 exactly 5 cycles later, for 1 cycle.
//  2. Back-to-back: in=32'hFFFF_FFFF, shamt=0..31 on consecutive cycles, out_ready=1
//     -> 32 consecutive results 32'hFFFF_FFFF<<k in order, in_ready stays 1.
//  3. Backpressure: stream 8 requests and hold out_ready=0 for 10 cycles
//     -> out/out_valid stable, in_ready=0 while stalled.
//     After release, all 8 results arrive in order with none lost.
//  4. Bubbles: requests on cycles 0,2,3,7 (in=32'hA5A5_A5A5, shamt=4)
//     -> 32'h5A5A_5A50 appears with out_valid=1 on the matching 4 cycles,
//     with out_valid=0 between them.
//  5. Reset mid-flight: assert rst_n=0 with 3 requests in the pipe
//     -> out_valid=0 immediately, and no results after deassert.
//     The first new request then completes with 5-cycle latency.
//  6. Random: 10k random in/shamt with random in_valid/out_ready
//     -> scoreboard matches in<<shamt in order, no comb loop on in_ready.

Source files
------------

// File: rtl/shift_left_logical_pipelined.sv
// Pipelined logical left shifter. Stage k conditionally shifts by 2^k; a single
// global stall freezes every stage while the last result waits for the consumer.
module shift_left_logical_pipelined #(
  parameter int unsigned N = 32,
  localparam int unsigned S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [N-1:0] i_in,
  input  logic [S-1:0] i_shamt,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_out
);

  logic [S-1:0] r_v;
  logic [N-1:0] r_d  [S];
  logic [S-1:0] r_sa [S];

  logic [S-1:0] w_v_nxt;
  logic [N-1:0] w_d_nxt  [S];
  logic [S-1:0] w_sa_nxt [S];
  logic         w_stall;
  logic [S-1:0] w_unused_sa;

  // Stall depends only on registered state and out_ready, never on in_valid.
  assign w_stall     = r_v[S-1] & ~i_out_ready;
  assign o_in_ready  = ~w_stall;
  assign o_out_valid = r_v[S-1];
  assign o_out       = r_d[S-1];

  assign w_v_nxt = {r_v[S-2:0], i_in_valid & o_in_ready};

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int unsigned Sh = 1 << k;
    if (k == 0) begin : g_first
      assign w_d_nxt[k]  = i_shamt[0] ? (i_in << Sh) : i_in;
      assign w_sa_nxt[k] = i_shamt;
    end else begin : g_rest
      assign w_d_nxt[k]  = r_sa[k-1][k] ? (r_d[k-1] << Sh) : r_d[k-1];
      assign w_sa_nxt[k] = r_sa[k-1];
    end
    // Low shamt bits are consumed upstream; keep the full field for uniformity.
    assign w_unused_sa[k] = ^r_sa[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v  <= '0;
      r_d  <= '{default: '0};
      r_sa <= '{default: '0};
    end else if (!w_stall) begin
      r_v  <= w_v_nxt;
      r_d  <= w_d_nxt;
      r_sa <= w_sa_nxt;
    end
  end

endmodule

// File: tb/tb_shift_left_logical_pipelined.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized run scored against in << shamt in acceptance order.
module tb_shift_left_logical_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_in;
  logic [4:0]  i_shamt;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out;

  shift_left_logical_pipelined #(.N(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in        (i_in),
    .i_shamt     (i_shamt),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out       (o_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [10];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_rx    = 0;
  int          n_acc   = 0;
  logic [31:0] sb_q [$];
  logic        sb_en = 1'b1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out = '0;
  logic        s_valid, s_in_ready, last_acc;
  logic [31:0] s_out;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, score, then return just after the next posedge.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    s_valid    = o_out_valid;
    s_out      = o_out;
    s_in_ready = o_in_ready;
    last_acc   = i_in_valid && o_in_ready;
    if (prev_stall) begin
      check_bit("hold_valid", o_out_valid, 1'b1);
      check32("hold_data", o_out, prev_out);
    end
    check_bit("in_ready_rule", o_in_ready, !(o_out_valid && !i_out_ready));
    if (sb_en) begin
      if (o_out_valid && i_out_ready) begin
        n_rx++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: got %h expected no result", o_out);
        end else begin
          e = sb_q.pop_front();
          check32("sb_data", o_out, e);
        end
      end
      if (last_acc) begin
        sb_q.push_back(i_in << i_shamt);
        n_acc++;
      end
    end
    prev_stall = o_out_valid && !i_out_ready;
    prev_out   = o_out;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    i_in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    check_int("drain_left", sb_q.size(), 0);
  endtask

  // Single request into an idle pipe: result must show after 5 edges for exactly 1 cycle.
  task automatic single_req(input logic [31:0] din, input logic [4:0] sh,
                            input logic [31:0] exp);
    int cnt = 0;
    i_out_ready = 1'b1;
    i_in = din;
    i_shamt = sh;
    i_in_valid = 1'b1;
    cycle();
    i_in_valid = 1'b0;
    i_in = $urandom;
    i_shamt = 5'($urandom_range(31, 0));
    do begin
      cnt++;
      cycle();
    end while (!s_valid && cnt < 20);
    check_int("latency", cnt, 5);
    check32("single_out", s_out, exp);
    cycle();
    check_bit("pulse_len", s_valid, 1'b0);
  endtask

  initial begin
    logic [7:0]  pat;
    logic        exp_v;
    int          sent, stall_cnt, rx0, cyc, sv;
    logic        stalling;
    logic [31:0] held;

    vecs[0] = '{32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1] = '{32'hA5A5_A5A5, 5'd4,  32'h5A5A_5A50};
    vecs[2] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[3] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[4] = '{32'h1234_5678, 5'd8,  32'h3456_7800};
    vecs[5] = '{32'h0000_FFFF, 5'd16, 32'hFFFF_0000};
    vecs[6] = '{32'h8000_0001, 5'd1,  32'h0000_0002};
    vecs[7] = '{32'h0000_0003, 5'd30, 32'hC000_0000};
    vecs[8] = '{32'hF0F0_F0F0, 5'd7,  32'h7878_7800};
    vecs[9] = '{32'hFFFF_FFFE, 5'd31, 32'h0000_0000};

    rst_n = 1'b0;
    i_in_valid = 1'b0;
    i_in = '0;
    i_shamt = '0;
    i_out_ready = 1'b1;
    #3;
    check_bit("rst_out_valid", o_out_valid, 1'b0);
    check32("rst_out", o_out, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bit("idle_in_ready", o_in_ready, 1'b1);
    check_bit("idle_out_valid", o_out_valid, 1'b0);

    // Directed vectors (first entry is the 1<<31 latency case).
    for (int i = 0; i < 10; i++) single_req(vecs[i].din, vecs[i].sh, vecs[i].exp);

    // Back-to-back shamt sweep.
    rx0 = n_rx;
    for (int k = 0; k < 32; k++) begin
      i_in = 32'hFFFF_FFFF;
      i_shamt = 5'(k);
      i_in_valid = 1'b1;
      cycle();
      check_bit("b2b_in_ready", s_in_ready, 1'b1);
    end
    drain();
    check_int("b2b_count", n_rx - rx0, 32);

    // Backpressure: 8 requests with a 10-cycle consumer stall.
    rx0 = n_rx;
    sent = 0;
    stall_cnt = 0;
    stalling = 1'b0;
    held = '0;
    i_out_ready = 1'b0;
    cyc = 0;
    while ((sent < 8 || sb_q.size() != 0) && cyc < 200) begin
      i_in_valid = (sent < 8);
      i_in = 32'h0101_0101 * (sent + 1);
      i_shamt = 5'(sent * 3);
      cycle();
      cyc++;
      if (last_acc) sent++;
      if (!i_out_ready && s_valid) begin
        if (!stalling) begin
          stalling = 1'b1;
          held = s_out;
        end else begin
          check32("bp_out_stable", s_out, held);
          check_bit("bp_in_ready", s_in_ready, 1'b0);
        end
        stall_cnt++;
        if (stall_cnt == 10) i_out_ready = 1'b1;
      end
    end
    check_int("bp_sent", sent, 8);
    check_int("bp_count", n_rx - rx0, 8);
    i_out_ready = 1'b1;

    // Bubbles: requests on cycles 0,2,3,7.
    pat = 8'b1000_1101;
    for (int t = 0; t < 16; t++) begin
      i_in = 32'hA5A5_A5A5;
      i_shamt = 5'd4;
      i_in_valid = (t < 8) ? pat[t] : 1'b0;
      cycle();
      exp_v = (t >= 5 && t < 13) ? pat[t-5] : 1'b0;
      check_bit("bubble_valid", s_valid, exp_v);
      if (exp_v) check32("bubble_data", s_out, 32'h5A5A_5A50);
    end
    drain();

    // Reset with 3 requests in flight.
    sb_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_in = 32'h0000_0011 << i;
      i_shamt = 5'd2;
      i_in_valid = 1'b1;
      cycle();
    end
    i_in_valid = 1'b0;
    cycle();
    cycle();
    check_bit("pre_reset_valid", o_out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("reset_out_valid", o_out_valid, 1'b0);
    check32("reset_out", o_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_stall = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_bit("post_reset_quiet", s_valid, 1'b0);
    end
    sb_en = 1'b1;
    single_req(32'h0000_0F0F, 5'd12, 32'h00F0_F000);

    // Random traffic.
    sv = n_acc;
    cyc = 0;
    while (n_acc - sv < 10000 && cyc < 40000) begin
      i_in_valid = ($urandom_range(3, 0) != 0);
      i_in = $urandom;
      i_shamt = 5'($urandom_range(31, 0));
      i_out_ready = ($urandom_range(3, 0) != 0);
      cycle();
      cyc++;
    end
    check_int("rand_accepted", (n_acc - sv >= 10000) ? 1 : 0, 1);
    i_out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
